// File: rtl/wb_stream_bridge.sv
// Wishbone classic responder that bridges register accesses onto a 32-bit TX/RX stream pair.
// Loopback (CONTROL[4]) is compiled in only when WB_STREAM_BRIDGE_LOOPBACK_EN is defined.
module wb_stream_bridge #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wbs_cyc,
    input  logic                  i_wbs_stb,
    input  logic                  i_wbs_we,
    input  logic [3:0]            i_wbs_sel,
    input  logic [31:0]           i_wbs_adr,
    input  logic [DATA_WIDTH-1:0] i_wbs_dat,
    output logic [DATA_WIDTH-1:0] o_wbs_dat,
    output logic                  o_wbs_ack,
    output logic                  o_wbs_int,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // RX storage is addressed by the full pointer so the skid entry beyond DEPTH has a home.
    logic [DATA_WIDTH-1:0] r_tx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [2*DEPTH];

    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_int;
    logic [1:0]            r_en;
    logic [7:0]            r_thresh;
    logic                  r_tx_flush;
    logic                  r_rx_flush;
    logic                  r_tx_ovf;
    logic                  r_rx_udf;
    logic [PW-1:0]         r_tx_wr;
    logic [PW-1:0]         r_tx_rd;
    logic [PW-1:0]         r_rx_wr;
    logic [PW-1:0]         r_rx_rd;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_rx_ready;

    logic                  w_lb;
    logic                  w_req;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_ctrl_wr;
    logic                  w_stat_wr;
    logic                  w_thr_wr;
    logic                  w_data_wr;
    logic                  w_data_rd;
    logic [PW-1:0]         w_tx_count;
    logic [PW-1:0]         w_rx_count;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic                  w_rx_empty;
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_tx_ready;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic [DATA_WIDTH-1:0] w_rx_data;
    logic [PW-1:0]         w_tx_wr_next;
    logic [PW-1:0]         w_tx_rd_next;
    logic [PW-1:0]         w_rx_wr_next;
    logic [PW-1:0]         w_rx_rd_next;
    logic [DATA_WIDTH-1:0] w_tx_head_next;
    logic [DATA_WIDTH-1:0] w_ctrl_rd;
    logic [DATA_WIDTH-1:0] w_stat_rd;
    logic                  w_int_next;
    logic                  w_unused;

    assign w_unused = ^{i_wbs_sel, i_wbs_adr[31:2]};

`ifdef WB_STREAM_BRIDGE_LOOPBACK_EN
    logic r_lb;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lb <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_lb <= i_wbs_dat[4];
        end
    end
    assign w_lb = r_lb;
`else
    assign w_lb = 1'b0;
`endif

    assign w_req     = i_wbs_cyc & i_wbs_stb & ~r_ack;
    assign w_wr      = w_req & i_wbs_we;
    assign w_rd      = w_req & ~i_wbs_we;
    assign w_ctrl_wr = w_wr & (i_wbs_adr[1:0] == 2'd0);
    assign w_stat_wr = w_wr & (i_wbs_adr[1:0] == 2'd1);
    assign w_thr_wr  = w_wr & (i_wbs_adr[1:0] == 2'd2);
    assign w_data_wr = w_wr & (i_wbs_adr[1:0] == 2'd3);
    assign w_data_rd = w_rd & (i_wbs_adr[1:0] == 2'd3);

    // Full/empty decisions use the occupancy at the start of the cycle.
    assign w_tx_count = r_tx_wr - r_tx_rd;
    assign w_rx_count = r_rx_wr - r_rx_rd;
    assign w_tx_full  = (w_tx_count >= DEPTH_P);
    assign w_tx_empty = (w_tx_count == '0);
    assign w_rx_empty = (w_rx_count == '0);

    assign w_tx_ready = w_lb ? (r_rx_ready & ~r_rx_flush) : i_tx_ready;
    assign w_tx_push  = w_data_wr & ~w_tx_full;
    assign w_tx_pop   = ~w_tx_empty & w_tx_ready & ~r_tx_flush;
    assign w_rx_push  = w_lb ? w_tx_pop : (i_rx_valid & r_rx_ready & ~r_rx_flush);
    assign w_rx_pop   = w_data_rd & ~w_rx_empty;
    assign w_rx_data  = w_lb ? r_tx_data : i_rx_data;

    assign w_tx_wr_next = r_tx_flush ? '0 : r_tx_wr + {{(PW-1){1'b0}}, w_tx_push};
    assign w_tx_rd_next = r_tx_flush ? '0 : r_tx_rd + {{(PW-1){1'b0}}, w_tx_pop};
    assign w_rx_wr_next = r_rx_flush ? '0 : r_rx_wr + {{(PW-1){1'b0}}, w_rx_push};
    assign w_rx_rd_next = r_rx_flush ? '0 : r_rx_rd + {{(PW-1){1'b0}}, w_rx_pop};

    // A word written into a slot that becomes the head this cycle bypasses the array.
    assign w_tx_head_next = (w_tx_push && (w_tx_rd_next == r_tx_wr)) ? i_wbs_dat
                          : r_tx_mem[w_tx_rd_next[DEPTH_LOG2-1:0]];

    assign w_ctrl_rd = {27'b0, w_lb, 2'b00, r_en};
    assign w_stat_rd = {r_tx_ovf, r_rx_udf, 6'b0, 8'(w_tx_count), 8'b0, 8'(w_rx_count)};

    assign w_int_next = (r_en[0] & (r_thresh != 8'd0) & (8'(w_rx_count) >= r_thresh))
                      | (r_en[1] & (r_tx_ovf | r_rx_udf));

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[DEPTH_LOG2-1:0]] <= i_wbs_dat;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= w_rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            if (!i_wbs_cyc) begin
                r_ack <= 1'b0;
            end else if (w_req) begin
                r_ack <= 1'b1;
            end else if (!i_wbs_stb) begin
                r_ack <= 1'b0;
            end
            if (w_rd) begin
                case (i_wbs_adr[1:0])
                    2'd0:    r_dat <= w_ctrl_rd;
                    2'd1:    r_dat <= w_stat_rd;
                    2'd2:    r_dat <= {24'b0, r_thresh};
                    default: r_dat <= w_rx_empty ? '0 : r_rx_mem[r_rx_rd];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= '0;
            r_thresh   <= '0;
            r_tx_flush <= 1'b0;
            r_rx_flush <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_rx_udf   <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            r_tx_flush <= w_ctrl_wr & i_wbs_dat[2];
            r_rx_flush <= w_ctrl_wr & i_wbs_dat[3];
            if (w_ctrl_wr) begin
                r_en <= i_wbs_dat[1:0];
            end
            if (w_thr_wr) begin
                r_thresh <= i_wbs_dat[7:0];
            end
            if (w_stat_wr && i_wbs_dat[31]) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_stat_wr && i_wbs_dat[30]) begin
                r_rx_udf <= 1'b0;
            end
            if (w_data_wr && w_tx_full) begin
                r_tx_ovf <= 1'b1;
            end
            if (w_data_rd && w_rx_empty) begin
                r_rx_udf <= 1'b1;
            end
            r_int <= w_int_next;
        end
    end

    // Ready lags occupancy by one cycle; the extra RX slot absorbs the resulting skid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_tx_data  <= '0;
            r_rx_ready <= 1'b0;
        end else begin
            r_tx_wr    <= w_tx_wr_next;
            r_tx_rd    <= w_tx_rd_next;
            r_rx_wr    <= w_rx_wr_next;
            r_rx_rd    <= w_rx_rd_next;
            r_tx_data  <= w_tx_head_next;
            r_rx_ready <= ~(w_rx_count >= DEPTH_P);
        end
    end

    assign o_wbs_ack  = r_ack;
    assign o_wbs_dat  = r_dat;
    assign o_wbs_int  = r_int;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = ~w_tx_empty & ~w_lb;
    assign o_rx_ready = r_rx_ready & ~w_lb;

endmodule

// File: tb/tb_wb_stream_bridge.sv
// Self-checking bench for wb_stream_bridge: queue-based reference model, directed and random traffic.
module tb_wb_stream_bridge;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic [31:0] o_wbs_dat, o_tx_data;
    logic        o_wbs_ack, o_wbs_int, o_tx_valid, o_rx_ready;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic [31:0] rx_data = '0;

    always #5 clk = ~clk;

    wb_stream_bridge #(.DEPTH_LOG2(DL2), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wbs_cyc(cyc), .i_wbs_stb(stb), .i_wbs_we(we), .i_wbs_sel(sel),
        .i_wbs_adr(adr), .i_wbs_dat(wdat), .o_wbs_dat(o_wbs_dat),
        .o_wbs_ack(o_wbs_ack), .o_wbs_int(o_wbs_int),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(tx_ready),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(o_rx_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60) $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60) $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, registers as plain variables.
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit          m_ovf, m_udf, m_ack, m_rd, m_int, m_rdy, m_txfl, m_rxfl, m_lb;
    bit [1:0]    m_en;
    bit [7:0]    m_thresh;
    logic [31:0] m_dat;

    task automatic model_step();
        int tc, rc;
        bit req, int_n, rdy_n, tpop, rpush, ntf, nrf;
        logic [31:0] lbd;
        if (!rst_n) begin
            m_tx.delete(); m_rx.delete();
            m_ovf = 0; m_udf = 0; m_ack = 0; m_rd = 0; m_int = 0; m_rdy = 0;
            m_txfl = 0; m_rxfl = 0; m_lb = 0; m_en = 0; m_thresh = 0;
            return;
        end
        tc = m_tx.size();
        rc = m_rx.size();
        req   = cyc && stb && !m_ack;
        int_n = (m_en[0] && m_thresh != 0 && rc >= int'(m_thresh)) || (m_en[1] && (m_ovf || m_udf));
        rdy_n = rc < DEPTH;
        ntf = 0; nrf = 0;
        lbd = (tc > 0) ? m_tx[0] : 32'h0;
        if (m_lb) begin
            tpop  = tc > 0 && m_rdy && !m_txfl && !m_rxfl;
            rpush = tpop;
        end else begin
            tpop  = tc > 0 && tx_ready && !m_txfl;
            rpush = rx_valid && m_rdy && !m_rxfl;
        end
        if (tpop) void'(m_tx.pop_front());
        if (req) begin
            m_rd = !we;
            case (adr[1:0])
                2'd0: if (we) begin
                          m_en = wdat[1:0]; ntf = wdat[2]; nrf = wdat[3];
`ifdef WB_STREAM_BRIDGE_LOOPBACK_EN
                          m_lb = wdat[4];
`endif
                      end else m_dat = {27'b0, m_lb, 2'b00, m_en};
                2'd1: if (we) begin
                          if (wdat[31]) m_ovf = 0;
                          if (wdat[30]) m_udf = 0;
                      end else m_dat = {m_ovf, m_udf, 6'b0, 8'(tc), 8'b0, 8'(rc)};
                2'd2: if (we) m_thresh = wdat[7:0];
                      else m_dat = {24'b0, m_thresh};
                default: if (we) begin
                          if (tc >= DEPTH) m_ovf = 1;
                          else m_tx.push_back(wdat);
                      end else begin
                          if (rc == 0) begin m_udf = 1; m_dat = 0; end
                          else m_dat = m_rx.pop_front();
                      end
            endcase
        end
        if (rpush) m_rx.push_back(m_lb ? lbd : rx_data);
        if (m_txfl) m_tx.delete();
        if (m_rxfl) m_rx.delete();
        m_txfl = ntf;
        m_rxfl = nrf;
        if (!cyc) m_ack = 0;
        else if (req) m_ack = 1;
        else if (!stb) m_ack = 0;
        m_int = int_n;
        m_rdy = rdy_n;
    endtask

    always @(posedge clk) model_step();

    bit          collect = 0;
    logic [31:0] got[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chkb("ack", o_wbs_ack, m_ack);
            if (m_ack && m_rd) chk("rdata", o_wbs_dat, m_dat);
            chkb("tx_valid", o_tx_valid, m_tx.size() > 0 && !m_lb);
            if (o_tx_valid && m_tx.size() > 0) chk("tx_data", o_tx_data, m_tx[0]);
            chkb("rx_ready", o_rx_ready, m_rdy && !m_lb);
            chkb("int", o_wbs_int, m_int);
            if (collect && o_tx_valid && tx_ready) got.push_back(o_tx_data);
        end
    end

    task automatic wb(input bit w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] r);
        int t;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = {30'b0, a}; wdat = d;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_wbs_ack && t < 8);
        if (!o_wbs_ack) begin
            n_vec++; n_err++;
            $display("FAIL wb_ack_timeout: got no ack, expected ack within 8 cycles at %0t", $time);
        end
        r = o_wbs_dat;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        wb(1'b0, a, 32'h0, r);
    endtask

    bit rand_on = 0;
    int rdy_pct = 5;

    always @(posedge clk) begin
        if (rand_on) begin
            #1;
            tx_ready = ($urandom_range(0, 9) < rdy_pct);
            rx_valid = ($urandom_range(0, 3) != 0);
            rx_data  = $urandom;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int t;
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_ack", o_wbs_ack, 1'b0);
        chk("rst_dat", o_wbs_dat, 32'h0);
        chkb("rst_tx_valid", o_tx_valid, 1'b0);
        chkb("rst_rx_ready", o_rx_ready, 1'b0);
        chkb("rst_int", o_wbs_int, 1'b0);
        chk("rst_tx_data", o_tx_data, 32'h0);
        rst_n = 1;
        @(negedge clk);
        chkb("rdy_before_edge", o_rx_ready, 1'b0);
        @(negedge clk);
        chkb("rdy_after_release", o_rx_ready, 1'b1);
        chkb("tx_valid_idle", o_tx_valid, 1'b0);

        rd(2'd1, r);
        chk("status_reset", r, 32'h0000_0000);

        // Three words held back, then released in order.
        for (int i = 1; i <= 3; i++) wr(2'd3, 32'hA5A5_0000 + i);
        rd(2'd1, r);
        chk("status_tx3", r, 32'h0003_0000);
        collect = 1;
        tx_ready = 1;
        repeat (8) @(posedge clk);
        #1;
        collect = 0;
        tx_ready = 0;
        chk("beats_n", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("beat", got[i], 32'hA5A5_0001 + i);
        chkb("tx_drained", o_tx_valid, 1'b0);

        // Overflow on the 17th write, then write-1-to-clear.
        for (int i = 0; i < 17; i++) wr(2'd3, 32'hB000_0000 + i);
        rd(2'd1, r);
        chk("status_ovf", r, 32'h8010_0000);
        wr(2'd1, 32'h8000_0000);
        rd(2'd1, r);
        chk("status_ovf_clr", r, 32'h0010_0000);
        wr(2'd0, 32'h0000_0004);
        rd(2'd1, r);
        chk("status_flushed", r, 32'h0000_0000);

        // Four words in from the stream, threshold interrupt.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rx_valid = 1; rx_data = 32'hC0DE_0000 + i;
            t = 0;
            @(negedge clk);
            while (!o_rx_ready && t < 20) begin @(negedge clk); t++; end
            chkb("rx_accept", o_rx_ready, 1'b1);
        end
        @(posedge clk); #1;
        rx_valid = 0;
        wr(2'd2, 32'd4);
        wr(2'd0, 32'd1);
        chkb("int_thresh", o_wbs_int, 1'b1);
        rd(2'd3, r);
        chk("rx_first", r, 32'hC0DE_0000);
        chkb("int_drop", o_wbs_int, 1'b0);
        for (int i = 1; i < 4; i++) begin
            rd(2'd3, r);
            chk("rx_rest", r, 32'hC0DE_0000 + i);
        end

        // Underflow with error interrupt enabled.
        wr(2'd0, 32'd2);
        rd(2'd3, r);
        chk("rx_empty_read", r, 32'h0);
        rd(2'd1, r);
        chk("status_udf", r, 32'h4000_0000);
        chkb("int_err", o_wbs_int, 1'b1);
        wr(2'd1, 32'h4000_0000);
        chkb("int_err_clr", o_wbs_int, 1'b0);

`ifdef WB_STREAM_BRIDGE_LOOPBACK_EN
        wr(2'd0, 32'h10);
        wr(2'd3, 32'h1234_5678);
        repeat (4) @(posedge clk);
        rd(2'd3, r);
        chk("loopback", r, 32'h1234_5678);
        wr(2'd0, 32'h0);
`endif

        // Randomised traffic: low then high outbound ready rate.
        rand_on = 1;
        for (int n = 0; n < 500; n++) begin
            logic [1:0]  a;
            logic [31:0] d;
            bit          w;
            if (n == 250) rdy_pct = 8;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            a = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 2));
            w = ($urandom_range(0, 1) == 1);
            case (a)
                2'd0: begin
                    d = $urandom_range(0, 3);
                    if ($urandom_range(0, 7) == 0) d = d | 32'h4;
                    if ($urandom_range(0, 7) == 0) d = d | 32'h8;
                end
                2'd2:    d = $urandom_range(0, 20);
                default: d = $urandom;
            endcase
            wb(w, a, d, r);
        end
        rand_on = 0;
        @(posedge clk); #1;
        rx_valid = 0; tx_ready = 0;

        // Reset asserted while a write is being acknowledged.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'd3; wdat = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        chkb("rst_mid_ack", o_wbs_ack, 1'b0);
        chkb("rst_mid_tx_valid", o_tx_valid, 1'b0);
        chkb("rst_mid_rx_ready", o_rx_ready, 1'b0);
        chkb("rst_mid_int", o_wbs_int, 1'b0);
        cyc = 0; stb = 0; we = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        rd(2'd1, r);
        chk("status_after_rst", r, 32'h0000_0000);
        rd(2'd0, r);
        chk("ctrl_after_rst", r, 32'h0000_0000);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_stream_bridge.md
Name: wb_stream_bridge

Overview:
- Wishbone classic responder (slave) that sits on a peripheral interconnect slot.
- It converts host-issued register reads and writes into a 32-bit valid/ready stream pair:
  - a TX FIFO, filled by Wishbone writes and drained on the outbound stream;
  - an RX FIFO, filled from the inbound stream and drained by Wishbone reads.
- It raises o_wbs_int on an RX fill threshold or on an error.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries); legal range 2..7.
DATA_WIDTH, 32, stream and Wishbone data width; fixed at 32.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_wbs_cyc  in  1  bus cycle
i_wbs_stb  in  1  strobe
i_wbs_we  in  1  1=write
i_wbs_sel  in  4  byte selects; ignored, full-word access only
i_wbs_adr  in  32  word address; only [1:0] decoded
i_wbs_dat  in  32  write data
o_wbs_dat  out  32  read data
o_wbs_ack  out  1  acknowledge
o_wbs_int  out  1  interrupt, level
o_tx_data  out  32  outbound stream data
o_tx_valid  out  1  outbound valid
i_tx_ready  in  1  outbound ready
i_rx_data  in  32  inbound stream data
i_rx_valid  in  1  inbound valid
o_rx_ready  out  1  inbound ready

Behaviour:
- Reset (rst_n low, async): all outputs 0, both FIFOs empty, all registers 0.
- Register map, by adr[1:0]:
  - 0 CONTROL, RW:
    - [0] RX threshold interrupt enable.
    - [1] error interrupt enable.
    - [2] TX flush, write-1 self-clearing, reads 0.
    - [3] RX flush, write-1 self-clearing, reads 0.
    - [4] loopback (optional feature).
  - 1 STATUS:
    - [31] tx_ovf sticky; [30] rx_udf sticky. Write-1-to-clear; other bits ignore writes.
    - [23:16] tx_count; [7:0] rx_count (zero-extended).
  - 2 RX_THRESH, RW: [7:0] threshold.
  - 3 DATA: write pushes TX FIFO; read pops RX FIFO.
- Wishbone handshake:
  - Request = cyc & stb & ~ack.
  - Ack asserts the cycle after a request is sampled, i.e. 1-cycle latency.
  - o_wbs_dat is valid in the same cycle as ack.
  - Ack stays high until stb falls, then deasserts the next cycle. Exactly one side effect per transaction.
  - cyc dropping mid-transaction clears ack next cycle; no side effect if the request had not yet been sampled.
- Side effects are committed on the sampling cycle:
  - DATA write with TX full: data dropped, tx_ovf set, ack still returned.
  - DATA read with RX empty: returns 0x00000000, rx_udf set, no pop.
- Full/empty decisions use the count at the start of the cycle:
  - A simultaneous WB push to a full TX FIFO and stream pop drops the push.
  - A simultaneous RX stream push and WB pop both proceed; count unchanged.
- Outbound stream:
  - o_tx_valid = TX not empty; o_tx_data = FIFO head (registered).
  - Transfer when valid & ready; head advances next cycle.
  - Data is held stable while valid & ~ready.
- Inbound stream:
  - o_rx_ready = registered ~rx_full; 0 in reset, 1 the first cycle after reset release.
  - A push occurs when i_rx_valid & o_rx_ready.
  - A push arriving while the FIFO became full this cycle is accepted. The FIFO has one skid entry beyond DEPTH, so capacity is DEPTH+1 and the reported count can reach DEPTH+1.
- Pointers: DEPTH_LOG2+1 bits, wrap naturally. Counts are saturation-free (bounded by capacity).
- Flush: empties the FIFO in the cycle after the write. Stream handshakes in that cycle are ignored for the flushed FIFO.
- Interrupt, registered, updated every cycle:
  o_wbs_int = (ctrl[0] & thresh!=0 & rx_count>=thresh) | (ctrl[1] & (tx_ovf|rx_udf)).
  Threshold 0 never fires.
- Reset mid-transaction: ack drops immediately, FIFOs empty, no partial state retained.

Optional Feature:
WB_STREAM_BRIDGE_LOOPBACK_EN
- Defined:
  - CONTROL[4]=1 routes the TX FIFO head directly into the RX FIFO, with RX ready as the TX ready.
  - External i_tx_ready and i_rx_valid are ignored; o_tx_valid=0; o_rx_ready=0.
- Undefined:
  - CONTROL[4] reads 0 and writes are ignored; no loopback logic is present.

Test Plan:
- Reset, then read STATUS -> 0x00000000. o_rx_ready=1 one cycle after rst_n rises; o_tx_valid=0.
- Write DATA 0xA5A5_0001..0xA5A5_0003 with i_tx_ready=0 -> STATUS[23:16]=3. Raise ready -> three beats in order, then o_tx_valid=0.
- 17 DATA writes at DEPTH=16 with ready=0 -> 17th dropped; STATUS=0x8010_0000. Write 0x8000_0000 to STATUS -> bit31 clears.
- Push 4 words via stream, RX_THRESH=4, CONTROL=1 -> o_wbs_int=1. One DATA read returns the first word and int drops.
- DATA read on empty RX with CONTROL=2 -> returns 0, STATUS[30]=1, o_wbs_int=1. Clear -> int=0.
- With loopback macro: CONTROL=0x10, write 0x1234_5678 -> readback of DATA returns 0x1234_5678; o_tx_valid never rises.
